// File: rtl/core_types_pkg.sv
// Shared types for the IF/MEM memory arbiter.
// The struct widths bound the widest bus the arbiter can be built for.
package core_types_pkg;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  // Fetches are always full-word reads.
  localparam logic [ARB_BE_W-1:0] ARB_BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  we;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;
endpackage

// File: rtl/arb_timer.sv
// Up-counter that saturates at LIMIT and flags when it sits there.
// Used both as the fetch starvation counter and the bus timeout counter.
module arb_timer #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  // Clear wins over increment; the count sticks at LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (inc && (cnt != LIM))  cnt <= cnt + W'(1);
  end

  assign expired = (cnt == LIM);
endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory bus between instruction fetch and the
// data stage. One transaction in flight; data has priority unless fetch has
// waited STARVE_LIMIT data grants. Flushed fetches complete on the bus but
// are not returned. A stuck bus is aborted after TIMEOUT busy cycles.
module mem_arbiter
  import core_types_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [BE_W-1:0]   dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              hold,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_t        state, state_d;
  arb_req_t          req_q, req_d;
  logic              mem_req_d, if_rvalid_d, dm_rvalid_d, bus_err_d;
  logic              drop, drop_d;
  logic [DATA_W-1:0] if_rdata_d, dm_rdata_d;
  logic              starve_exp, tmo_exp;
  logic              idle_ok, gnt_if, gnt_dm, busy, ack_done, abort, fin, if_kill;

  // No grant while any completion pulse is out, so a requester that just
  // finished is never re-granted on its stale request.
  assign idle_ok  = (state == IDLE) && !if_rvalid && !dm_rvalid;
  assign gnt_if   = idle_ok && if_req && !flush && (!dm_req || starve_exp);
  assign gnt_dm   = idle_ok && dm_req && !gnt_if;
  assign busy     = (state != IDLE);
  assign ack_done = busy && mem_ack;
  assign abort    = busy && !mem_ack && tmo_exp;   // ack in the expiry cycle wins
  assign fin      = ack_done || abort;
  assign if_kill  = drop || flush;

  arb_timer #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk     (Clock),
    .rst_n   (nReset),
    .clr     (gnt_if || !if_req),
    .inc     (gnt_dm && if_req),
    .expired (starve_exp)
  );

  arb_timer #(.LIMIT(TIMEOUT - 1)) u_tmo (
    .clk     (Clock),
    .rst_n   (nReset),
    .clr     (gnt_if || gnt_dm),
    .inc     (busy && !fin),
    .expired (tmo_exp)
  );

  // Next state, next bus request and completion pulses.
  always_comb begin
    state_d     = state;
    req_d       = req_q;
    mem_req_d   = mem_req;
    drop_d      = drop;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    unique case (state)
      IDLE: begin
        if (gnt_if) begin
          req_d.addr  = ARB_ADDR_W'(if_addr);
          req_d.we    = 1'b0;
          req_d.be    = ARB_BE_ALL;
          req_d.wdata = '0;
          mem_req_d   = 1'b1;
          state_d     = BUSY_IF;
        end else if (gnt_dm) begin
          req_d.addr  = ARB_ADDR_W'(dm_addr);
          req_d.we    = dm_we;
          req_d.be    = ARB_BE_W'(dm_be);
          req_d.wdata = ARB_DATA_W'(dm_wdata);
          mem_req_d   = 1'b1;
          state_d     = BUSY_DM;
        end
      end
      BUSY_IF: begin
        if (flush) drop_d = 1'b1;
        if (fin) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          bus_err_d = abort;
          if (!if_kill) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = ack_done ? mem_rdata : '0;
          end
        end
      end
      BUSY_DM: begin
        if (fin) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          bus_err_d   = abort;
          dm_rvalid_d = 1'b1;
          if (abort)          dm_rdata_d = '0;
          else if (!req_q.we) dm_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All bus-facing and completion outputs are registered here.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      req_q     <= '0;
      mem_req   <= 1'b0;
      drop      <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state     <= state_d;
      req_q     <= req_d;
      mem_req   <= mem_req_d;
      drop      <= drop_d;
      if_rvalid <= if_rvalid_d;
      dm_rvalid <= dm_rvalid_d;
      bus_err   <= bus_err_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
    end
  end

  assign mem_we    = req_q.we;
  assign mem_be    = BE_W'(req_q.be);
  assign mem_addr  = ADDR_W'(req_q.addr);
  assign mem_wdata = DATA_W'(req_q.wdata);

  // Freeze the pipeline while a live request has not yet completed.
  assign hold = (dm_req & ~dm_rvalid) | (if_req & ~if_rvalid & ~flush);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for simple fetch/load/store
// traffic, then hand sequences for starvation, flush, timeout and reset.
module tb_mem_arbiter;
  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        hold, bus_err, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .Clock(Clock), .nReset(nReset), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .hold(hold), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_drv;
    logic [31:0] e_drd;
    logic        e_hold;
  } vec_t;

  vec_t tbl[11];
  logic [31:0] gnt_addr[6];
  logic [31:0] exp_gnt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int ng;
    logic prev;

    // inputs applied before an edge; expected outputs just after it
    //          ifr   if_addr       dmr   we    be     dm_addr       dm_wdata      ack   rdata
    //          req   we    be     addr          wdata         irv   ird           drv   drd           hold
    tbl[0]  = '{1'b1, 32'h100,      1'b0, 1'b0, 4'h0,  32'h0,        32'h0,        1'b0, 32'h0,
                1'b1, 1'b0, 4'hF,  32'h100,      32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
    tbl[1]  = '{1'b1, 32'h100,      1'b0, 1'b0, 4'h0,  32'h0,        32'h0,        1'b0, 32'h0,
                1'b1, 1'b0, 4'hF,  32'h100,      32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
    tbl[2]  = '{1'b1, 32'h100,      1'b0, 1'b0, 4'h0,  32'h0,        32'h0,        1'b1, 32'h12345678,
                1'b1, 1'b0, 4'hF,  32'h100,      32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
    tbl[3]  = '{1'b1, 32'h100,      1'b0, 1'b0, 4'h0,  32'h0,        32'h0,        1'b0, 32'h0,
                1'b0, 1'b0, 4'hF,  32'h100,      32'h0,        1'b1, 32'h12345678, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0,  32'h0,        32'h0,        1'b0, 32'h0,
                1'b0, 1'b0, 4'hF,  32'h100,      32'h0,        1'b0, 32'h12345678, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'hF,  32'h3000,     32'h0,        1'b1, 32'hA5A5A5A5,
                1'b1, 1'b0, 4'hF,  32'h3000,     32'h0,        1'b0, 32'h12345678, 1'b0, 32'h0,        1'b1};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'hF,  32'h3000,     32'h0,        1'b0, 32'h0,
                1'b0, 1'b0, 4'hF,  32'h3000,     32'h0,        1'b0, 32'h12345678, 1'b1, 32'hA5A5A5A5, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0,  32'h0,        32'h0,        1'b0, 32'h0,
                1'b0, 1'b0, 4'hF,  32'h3000,     32'h0,        1'b0, 32'h12345678, 1'b0, 32'hA5A5A5A5, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 4'h3,  32'h2000,     32'hDEADBEEF, 1'b1, 32'h55555555,
                1'b1, 1'b1, 4'h3,  32'h2000,     32'hDEADBEEF, 1'b0, 32'h12345678, 1'b0, 32'hA5A5A5A5, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 4'h3,  32'h2000,     32'hDEADBEEF, 1'b0, 32'h0,
                1'b0, 1'b1, 4'h3,  32'h2000,     32'hDEADBEEF, 1'b0, 32'h12345678, 1'b1, 32'hA5A5A5A5, 1'b0};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'h0,  32'h0,        32'h0,        1'b0, 32'h0,
                1'b0, 1'b1, 4'h3,  32'h2000,     32'hDEADBEEF, 1'b0, 32'h12345678, 1'b0, 32'hA5A5A5A5, 1'b0};
    exp_gnt = '{32'h500, 32'h500, 32'h500, 32'h500, 32'h400, 32'h500};
    for (int i = 0; i < 6; i++) gnt_addr[i] = '0;

    // reset state
    repeat (2) @(posedge Clock);
    #1;
    chk("rst mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst if_rvalid", {31'b0, if_rvalid}, 32'h0);
    chk("rst dm_rvalid", {31'b0, dm_rvalid}, 32'h0);
    chk("rst bus_err", {31'b0, bus_err}, 32'h0);
    chk("rst hold", {31'b0, hold}, 32'h0);
    @(negedge Clock);
    nReset = 1'b1;

    // fetch with 3-cycle ack, then load, then store (mem_ack set before the
    // edge where it is sampled, so ack sits in the vector preceding its effect)
    for (int i = 0; i < 11; i++) begin
      if_req = tbl[i].if_req;  if_addr = tbl[i].if_addr;
      dm_req = tbl[i].dm_req;  dm_we = tbl[i].dm_we;  dm_be = tbl[i].dm_be;
      dm_addr = tbl[i].dm_addr; dm_wdata = tbl[i].dm_wdata;
      step();
      chk($sformatf("v%0d mem_req", i),   {31'b0, mem_req},   {31'b0, tbl[i].e_req});
      chk($sformatf("v%0d mem_we", i),    {31'b0, mem_we},    {31'b0, tbl[i].e_we});
      chk($sformatf("v%0d mem_be", i),    {28'b0, mem_be},    {28'b0, tbl[i].e_be});
      chk($sformatf("v%0d mem_addr", i),  mem_addr,           tbl[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata,          tbl[i].e_wdata);
      chk($sformatf("v%0d if_rvalid", i), {31'b0, if_rvalid}, {31'b0, tbl[i].e_irv});
      chk($sformatf("v%0d if_rdata", i),  if_rdata,           tbl[i].e_ird);
      chk($sformatf("v%0d dm_rvalid", i), {31'b0, dm_rvalid}, {31'b0, tbl[i].e_drv});
      chk($sformatf("v%0d dm_rdata", i),  dm_rdata,           tbl[i].e_drd);
      chk($sformatf("v%0d hold", i),      {31'b0, hold},      {31'b0, tbl[i].e_hold});
      mem_ack = tbl[i].ack;  mem_rdata = tbl[i].rdata;
    end
    mem_ack = 1'b0;

    // starvation: both held, 1-cycle ack responder
    if_addr = 32'h400; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h500; dm_wdata = '0;
    if_req = 1'b1; dm_req = 1'b1;
    ng = 0; prev = 1'b0;
    for (int c = 0; c < 200 && ng < 6; c++) begin
      step();
      if (mem_req && !prev) begin gnt_addr[ng] = mem_addr; ng++; end
      prev = mem_req;
      if (if_rvalid) if_req = 1'b0;
      mem_ack = mem_req;
      mem_rdata = mem_addr ^ 32'h5A5A0000;
    end
    chk("starve grant count", 32'(ng), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("starve grant%0d", i), gnt_addr[i], exp_gnt[i]);
    step();
    chk("starve last dm_rvalid", {31'b0, dm_rvalid}, 32'h1);
    chk("starve dm_rdata", dm_rdata, 32'h5A5A0500);
    chk("starve if_rdata", if_rdata, 32'h5A5A0400);
    dm_req = 1'b0; if_req = 1'b0; mem_ack = 1'b0;
    step();

    // flush during BUSY_IF; pending load granted right after
    if_req = 1'b1; if_addr = 32'h600;
    step();
    chk("flush grant if", mem_addr, 32'h600);
    flush = 1'b1;
    #1;
    chk("flush hold", {31'b0, hold}, 32'h0);
    step();
    flush = 1'b0; if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h700;
    step();
    chk("flush still busy", {31'b0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step();
    chk("flush ack mem_req", {31'b0, mem_req}, 32'h0);
    chk("flush if_rvalid", {31'b0, if_rvalid}, 32'h0);
    chk("flush if_rdata kept", if_rdata, 32'h5A5A0400);
    mem_ack = 1'b0;
    step();
    chk("flush dm grant", {31'b0, mem_req}, 32'h1);
    chk("flush dm addr", mem_addr, 32'h700);
    chk("flush no late if_rvalid", {31'b0, if_rvalid}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    step();
    chk("flush dm_rvalid", {31'b0, dm_rvalid}, 32'h1);
    chk("flush dm_rdata", dm_rdata, 32'h11112222);
    mem_ack = 1'b0; dm_req = 1'b0;
    step();

    // timeout: no ack for 8 busy cycles
    dm_req = 1'b1; dm_addr = 32'h800;
    step();
    chk("tmo grant", {31'b0, mem_req}, 32'h1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("tmo busy%0d mem_req", i), {31'b0, mem_req}, 32'h1);
      chk($sformatf("tmo busy%0d bus_err", i), {31'b0, bus_err}, 32'h0);
    end
    step();
    chk("tmo mem_req drop", {31'b0, mem_req}, 32'h0);
    chk("tmo bus_err", {31'b0, bus_err}, 32'h1);
    chk("tmo dm_rvalid", {31'b0, dm_rvalid}, 32'h1);
    chk("tmo dm_rdata", dm_rdata, 32'h0);
    dm_req = 1'b0;
    step();
    chk("tmo bus_err pulse", {31'b0, bus_err}, 32'h0);
    // ack arriving in the expiry cycle wins
    dm_req = 1'b1; dm_addr = 32'h900;
    step();
    chk("tmo2 grant", mem_addr, 32'h900);
    for (int i = 1; i < 8; i++) step();
    mem_ack = 1'b1; mem_rdata = 32'h33334444;
    step();
    chk("tmo2 mem_req", {31'b0, mem_req}, 32'h0);
    chk("tmo2 bus_err", {31'b0, bus_err}, 32'h0);
    chk("tmo2 dm_rvalid", {31'b0, dm_rvalid}, 32'h1);
    chk("tmo2 dm_rdata", dm_rdata, 32'h33334444);
    mem_ack = 1'b0; dm_req = 1'b0;
    step();

    // reset in BUSY_DM drops mem_req at once
    dm_req = 1'b1; dm_addr = 32'hA00;
    step();
    chk("rst2 grant", {31'b0, mem_req}, 32'h1);
    #2 nReset = 1'b0;
    #1;
    chk("rst2 mem_req async", {31'b0, mem_req}, 32'h0);
    chk("rst2 dm_rvalid", {31'b0, dm_rvalid}, 32'h0);
    dm_req = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
    if_req = 1'b1; if_addr = 32'hB00;
    step();
    chk("rst2 if grant", {31'b0, mem_req}, 32'h1);
    chk("rst2 if addr", mem_addr, 32'hB00);
    chk("rst2 if be", {28'b0, mem_be}, 32'hF);
    mem_ack = 1'b1; mem_rdata = 32'h77778888;
    step();
    chk("rst2 if_rvalid", {31'b0, if_rvalid}, 32'h1);
    chk("rst2 if_rdata", if_rdata, 32'h77778888);
    mem_ack = 1'b0; if_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
